// File: rtl/l1ca_acq_scheduler_if.sv
// rtl/l1ca_acq_scheduler_if.sv - detection handshake bundle between scheduler and channel allocation
interface l1ca_acq_scheduler_if;
   logic        det_valid;
   logic        det_ready;
   logic [5:0]  det_sv;
   logic [11:0] det_code;
   logic [4:0]  det_dop;
   logic [31:0] det_power;

   modport master (
      output det_valid, det_sv, det_code, det_dop, det_power,
      input  det_ready
   );

   modport slave (
      input  det_valid, det_sv, det_code, det_dop, det_power,
      output det_ready
   );
endinterface

// File: rtl/l1ca_acq_scheduler.sv
// rtl/l1ca_acq_scheduler.sv - L1 C/A search sequencer over an SV mask; ACQ_CONTINUOUS_EN restarts passes back to back
module l1ca_acq_scheduler #(
   parameter int N_SV          = 32,
   parameter int MAX_RETRY     = 1,
   parameter int START_TIMEOUT = 16
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  enable,
   input  logic [N_SV-1:0]       sv_mask,
   input  logic [31:0]           threshold,
   output logic                  search_start,
   output logic [5:0]            search_sv,
   input  logic                  search_busy,
   input  logic [31:0]           search_acc,
   input  logic [11:0]           search_code,
   input  logic [4:0]            search_dop,
   l1ca_acq_scheduler_if.master  det,
   output logic                  scan_done,
   output logic [5:0]            det_count,
   output logic                  busy
);

   localparam int IW = $clog2(N_SV + 1);
   localparam int TW = $clog2(START_TIMEOUT + 1);
   localparam logic [IW-1:0] IDX_END   = IW'(N_SV);
   localparam logic [TW-1:0] TMO_LAST  = TW'(START_TIMEOUT - 1);
   localparam logic [1:0]    RETRY_MAX = 2'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE, S_SELECT, S_START, S_WAIT_HI, S_WAIT_LO, S_EVAL, S_OUTPUT, S_NEXT
   } state_t;

   state_t          state_q, state_d;
   logic [N_SV-1:0] mask_q;
   logic [N_SV:0]   mask_ext;
   logic [IW-1:0]   idx_q;
   logic [1:0]      retry_q;
   logic [TW-1:0]   tmo_q;
   logic            need_low_q;
   logic            hit;
   logic            do_latch, do_done, do_found, do_skip;

   // extra zero bit lets the index sit at N_SV without an out-of-range select
   assign mask_ext     = {1'b0, mask_q};
   assign search_start = (state_q == S_START) && enable;
   assign busy         = (state_q != S_IDLE);
   assign det.det_valid = (state_q == S_OUTPUT);

   // state register
   always_ff @(posedge clk) begin
      if (!nrst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // next-state decode and datapath strobes
   always_comb begin
      state_d  = state_q;
      do_latch = 1'b0;
      do_done  = 1'b0;
      do_found = 1'b0;
      do_skip  = 1'b0;
      hit      = (search_acc > threshold);
      case (state_q)
         S_IDLE: begin
            if (enable && !need_low_q) begin
               state_d  = S_SELECT;
               do_latch = 1'b1;
            end
         end
         S_SELECT: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (idx_q == IDX_END) begin
               do_done = 1'b1;
`ifdef ACQ_CONTINUOUS_EN
               state_d  = S_SELECT;
               do_latch = 1'b1;
`else
               state_d  = S_IDLE;
`endif
            end else if (mask_ext[idx_q]) begin
               state_d  = S_START;
               do_found = 1'b1;
            end else begin
               do_skip = 1'b1;
            end
         end
         S_START:   state_d = enable ? S_WAIT_HI : S_IDLE;
         S_WAIT_HI: begin
            if (search_busy)                    state_d = S_WAIT_LO;
            else if (tmo_q + TW'(1) == TMO_LAST) state_d = enable ? S_START : S_IDLE;
         end
         S_WAIT_LO: begin
            if (!search_busy) state_d = enable ? S_EVAL : S_IDLE;
         end
         S_EVAL: begin
            if (hit)                    state_d = S_OUTPUT;
            else if (retry_q < RETRY_MAX) state_d = S_START;
            else                        state_d = S_NEXT;
         end
         S_OUTPUT: begin
            if (det.det_ready) state_d = enable ? S_NEXT : S_IDLE;
         end
         S_NEXT:  state_d = enable ? S_SELECT : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // scan index, retry/timeout counters, detection capture
   always_ff @(posedge clk) begin
      if (!nrst) begin
         mask_q        <= '0;
         idx_q         <= '0;
         retry_q       <= '0;
         tmo_q         <= '0;
         need_low_q    <= 1'b0;
         search_sv     <= '0;
         scan_done     <= 1'b0;
         det_count     <= '0;
         det.det_sv    <= '0;
         det.det_code  <= '0;
         det.det_dop   <= '0;
         det.det_power <= '0;
      end else begin
         scan_done <= do_done;
         if (do_done)      need_low_q <= 1'b1;
         else if (!enable) need_low_q <= 1'b0;
         if (do_latch) begin
            mask_q    <= sv_mask;
            idx_q     <= '0;
            retry_q   <= '0;
            det_count <= '0;
         end
         if (do_skip) idx_q <= idx_q + IW'(1);
         if (do_found) search_sv <= 6'(idx_q) + 6'd1;
         if (state_q == S_START)   tmo_q <= '0;
         if (state_q == S_WAIT_HI) tmo_q <= tmo_q + TW'(1);
         if (state_q == S_EVAL) begin
            if (hit) begin
               det.det_sv    <= search_sv;
               det.det_code  <= search_code;
               det.det_dop   <= search_dop;
               det.det_power <= search_acc;
               if (det_count != 6'd63) det_count <= det_count + 6'd1;
            end else if (retry_q < RETRY_MAX) begin
               retry_q <= retry_q + 2'd1;
            end
         end
         if (state_q == S_NEXT && enable) begin
            retry_q <= '0;
            idx_q   <= idx_q + IW'(1);
         end
      end
   end

endmodule

// File: tb/tb_l1ca_acq_scheduler.sv
// tb/tb_l1ca_acq_scheduler.sv - directed bench for l1ca_acq_scheduler with a search engine model
module tb_l1ca_acq_scheduler;
   logic        clk = 1'b0;
   logic        nrst;
   logic        enable;
   logic [31:0] sv_mask;
   logic [31:0] threshold;
   logic        search_start;
   logic [5:0]  search_sv;
   logic        search_busy;
   logic [31:0] search_acc;
   logic [11:0] search_code;
   logic [4:0]  search_dop;
   logic        scan_done;
   logic [5:0]  det_count;
   logic        busy;

   l1ca_acq_scheduler_if det_if();

   l1ca_acq_scheduler dut (
      .clk          (clk),
      .nrst         (nrst),
      .enable       (enable),
      .sv_mask      (sv_mask),
      .threshold    (threshold),
      .search_start (search_start),
      .search_sv    (search_sv),
      .search_busy  (search_busy),
      .search_acc   (search_acc),
      .search_code  (search_code),
      .search_dop   (search_dop),
      .det          (det_if.master),
      .scan_done    (scan_done),
      .det_count    (det_count),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] acc_tab [0:63];
   int          ignore_until = 0;
   int          cyc          = 0;
   int          start_count  = 0;
   int          hs_count     = 0;
   int          sd_count     = 0;
   int          dv_count     = 0;
   logic [5:0]  start_log [0:255];
   int          start_cyc [0:255];
   logic [5:0]  last_det_sv;
   logic [31:0] last_det_pow;
   logic [3:0]  eng_cnt;

   // engine model plus event monitors
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (det_if.det_valid) dv_count <= dv_count + 1;
      if (scan_done) sd_count <= sd_count + 1;
      if (det_if.det_valid && det_if.det_ready) begin
         hs_count     <= hs_count + 1;
         last_det_sv  <= det_if.det_sv;
         last_det_pow <= det_if.det_power;
      end
      if (!nrst) begin
         eng_cnt     <= '0;
         search_busy <= 1'b0;
         search_acc  <= '0;
         search_code <= '0;
         search_dop  <= '0;
      end else if (search_start) begin
         start_log[start_count[7:0]] <= search_sv;
         start_cyc[start_count[7:0]] <= cyc;
         start_count <= start_count + 1;
         if (start_count >= ignore_until) begin
            eng_cnt     <= 4'd6;
            search_acc  <= acc_tab[search_sv];
            search_code <= 12'(search_sv) * 12'd10 + 12'd3;
            search_dop  <= 5'(search_sv) + 5'd4;
         end
      end else if (eng_cnt != 4'd0) begin
         eng_cnt     <= eng_cnt - 4'd1;
         search_busy <= (eng_cnt != 4'd1);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(input string tag);
      logic ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (scan_done) begin ok = 1'b1; break; end
      end
      chk(tag, 64'(ok), 64'd1);
   endtask

   task automatic wait_ebusy(input logic lvl, input string tag);
      logic ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (search_busy == lvl) begin ok = 1'b1; break; end
      end
      chk(tag, 64'(ok), 64'd1);
   endtask

   task automatic idle_gap();
      enable = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy && !search_busy) break;
      end
      @(negedge clk);
      chk("idle_gap", 64'(busy), 64'd0);
   endtask

   int base_s, base_h, base_sd, base_dv, elapsed;
   logic got;

   initial begin
      for (int i = 0; i < 64; i++) acc_tab[i] = 32'd0;
      nrst = 1'b0; enable = 1'b0; sv_mask = '0; threshold = '0;
      det_if.det_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_start", 64'(search_start), 64'd0);
      chk("rst_valid", 64'(det_if.det_valid), 64'd0);
      chk("rst_done", 64'(scan_done), 64'd0);
      chk("rst_count", 64'(det_count), 64'd0);
      chk("rst_sv", 64'(search_sv), 64'd0);
      chk("rst_power", 64'(det_if.det_power), 64'd0);
      nrst = 1'b1;
      @(negedge clk);

      // two SVs, one hit and one retried miss
      acc_tab[1] = 32'd5000; acc_tab[3] = 32'd200;
      sv_mask = 32'h0000_0005; threshold = 32'd1000; det_if.det_ready = 1'b1;
      base_s = start_count; base_h = hs_count; base_sd = sd_count;
      enable = 1'b1;
      wait_done("t1_done");
      chk("t1_nstart", 64'(start_count - base_s), 64'd3);
      chk("t1_sv0", 64'(start_log[base_s[7:0]]), 64'd1);
      chk("t1_sv1", 64'(start_log[8'(base_s + 1)]), 64'd3);
      chk("t1_sv2", 64'(start_log[8'(base_s + 2)]), 64'd3);
      chk("t1_ndet", 64'(hs_count - base_h), 64'd1);
      chk("t1_detsv", 64'(last_det_sv), 64'd1);
      chk("t1_detpow", 64'(last_det_pow), 64'd5000);
      chk("t1_count", 64'(det_count), 64'd1);
      @(negedge clk);
      chk("t1_nscan", 64'(sd_count - base_sd), 64'd1);
      idle_gap();

      // empty mask: pass ends after N_SV+1 cycles with no search
      sv_mask = '0;
      base_s = start_count;
      enable = 1'b1;
      elapsed = -1;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (scan_done) begin elapsed = i - 1; break; end
      end
      chk("t2_latency", 64'(elapsed), 64'd33);
      chk("t2_nstart", 64'(start_count - base_s), 64'd0);
      chk("t2_count", 64'(det_count), 64'd0);
      idle_gap();

      // consumer stalls for 50 cycles with a detection pending
      acc_tab[2] = 32'd7000; acc_tab[4] = 32'd100;
      sv_mask = 32'h0000_000A; det_if.det_ready = 1'b0;
      base_s = start_count;
      enable = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (det_if.det_valid) begin got = 1'b1; break; end
      end
      chk("t3_valid", 64'(got), 64'd1);
      for (int i = 0; i < 50; i++) begin
         chk("t3_hold", {8'd0, det_if.det_valid, det_if.det_sv, det_if.det_code, det_if.det_dop, det_if.det_power},
             {8'd0, 1'b1, 6'd2, 12'd23, 5'd6, 32'd7000});
         chk("t3_nostart", 64'(start_count - base_s), 64'd1);
         @(negedge clk);
      end
      det_if.det_ready = 1'b1;
      @(negedge clk);
      chk("t3_drop", 64'(det_if.det_valid), 64'd0);
      wait_done("t3_done");
      chk("t3_nstart", 64'(start_count - base_s), 64'd3);
      idle_gap();

      // engine drops the first start; scheduler re-pulses after the timeout
      acc_tab[6] = 32'd3000;
      sv_mask = 32'h0000_0020;
      base_s = start_count; base_h = hs_count;
      ignore_until = start_count + 1;
      enable = 1'b1;
      wait_done("t4_done");
      chk("t4_nstart", 64'(start_count - base_s), 64'd2);
      chk("t4_gap", 64'(start_cyc[8'(base_s + 1)] - start_cyc[base_s[7:0]]), 64'd16);
      chk("t4_resv", 64'(start_log[8'(base_s + 1)]), 64'd6);
      chk("t4_ndet", 64'(hs_count - base_h), 64'd1);
      idle_gap();

      // abort while the engine is busy on a strong SV
      acc_tab[5] = 32'd9000;
      sv_mask = 32'h0000_0010;
      base_s = start_count;
      enable = 1'b1;
      wait_ebusy(1'b1, "t5_ebusy");
      enable = 1'b0;
      base_dv = dv_count; base_sd = sd_count;
      wait_ebusy(1'b0, "t5_eidle");
      chk("t5_busy_hold", 64'(busy), 64'd1);
      @(negedge clk);
      chk("t5_busy_fall", 64'(busy), 64'd0);
      repeat (10) @(negedge clk);
      chk("t5_novalid", 64'(dv_count - base_dv), 64'd0);
      chk("t5_noscan", 64'(sd_count - base_sd), 64'd0);
      chk("t5_nstart", 64'(start_count - base_s), 64'd1);
      idle_gap();

      // power equal to threshold is a miss and is retried
      acc_tab[1] = 32'd1000;
      sv_mask = 32'h0000_0001; threshold = 32'd1000;
      base_s = start_count; base_h = hs_count;
      enable = 1'b1;
      wait_done("t6_done");
      chk("t6_nstart", 64'(start_count - base_s), 64'd2);
      chk("t6_ndet", 64'(hs_count - base_h), 64'd0);
`ifdef ACQ_CONTINUOUS_EN
      chk("t6_restart", 64'(busy), 64'd1);
      @(negedge clk);
      chk("t6_running", 64'(busy), 64'd1);
`else
      chk("t6_stop", 64'(busy), 64'd0);
      repeat (3) @(negedge clk);
      chk("t6_stay", 64'(busy), 64'd0);
      chk("t6_nostart", 64'(start_count - base_s), 64'd2);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      chk("t6_rearm", 64'(busy), 64'd1);
`endif
      idle_gap();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/l1ca_acq_scheduler.md
Name: l1ca_acq_scheduler

Overview:
- Sequences the L1 C/A search engine across a list of candidate SVs.
- Per SV: pulses the engine's start, waits for its busy window to close, and compares peak correlation power against a programmable threshold.
- Presents detections to the channel-allocation logic over a valid/ready handshake.
- Sits between the receiver control registers and the search engine. It is the only master of the engine's start and sv inputs.

Parameters:
- N_SV, 32, number of candidate SVs; mask bit k selects SV number k+1.
- MAX_RETRY, 1, extra searches of a non-detected SV before moving on (0..3).
- START_TIMEOUT, 16, cycles to wait for search_busy to rise after search_start before re-pulsing.

Ports:
- clk  in  1  clock
- nrst  in  1  reset; synchronous, active-low
- enable  in  1  level; high requests scanning
- sv_mask  in  N_SV  candidate SV set, sampled at scan start
- threshold  in  32  detection threshold on I^2+Q^2 power
- search_start  out  1  one-cycle start pulse to search engine
- search_sv  out  6  SV number (1..N_SV) driven to engine; held for the whole search
- search_busy  in  1  engine busy
- search_acc  in  32  engine peak power
- search_code  in  12  engine code index of peak
- search_dop  in  5  engine Doppler bin of peak
- det_valid  out  1  detection available
- det_ready  in  1  consumer accepts detection
- det_sv  out  6  detected SV number
- det_code  out  12  code index
- det_dop  out  5  Doppler bin
- det_power  out  32  peak power
- scan_done  out  1  one-cycle pulse at end of a pass
- det_count  out  6  detections in current/last pass
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; internal mask, index and retry counter cleared.
- IDLE -> SELECT when enable=1. On entry to SELECT, latch sv_mask into mask_q, clear index, retry counter and det_count.
- SELECT: scan index upward for the next set bit of mask_q, one bit per cycle.
  - Found: search_sv <= index+1, go to START.
  - index reaches N_SV with no set bit: pulse scan_done, go to IDLE.
  - All-zero mask: scan_done asserts N_SV+1 cycles after scan start.
- START: assert search_start for exactly one cycle, clear the timeout counter, go to WAIT_HI.
- WAIT_HI:
  - search_busy=1 -> WAIT_LO.
  - Counter reaches START_TIMEOUT-1 -> back to START (re-pulse).
- WAIT_LO: on search_busy=0 -> EVAL. search_sv stays stable throughout.
- EVAL (1 cycle): hit when search_acc > threshold (unsigned, strict).
  - Hit: latch det_* from search_* and power, increment det_count (saturating at 63), go to OUTPUT.
  - Miss, retry counter < MAX_RETRY: increment retry counter, go to START (same SV).
  - Miss otherwise: go to NEXT.
- OUTPUT: det_valid=1 with det_* held stable until det_ready=1. On handshake, det_valid drops the next cycle and the state goes to NEXT. det_ready while det_valid=0 is ignored.
- NEXT: clear retry counter, index+1, go to SELECT.
- enable=0 mid-pass:
  - In SELECT/START/NEXT: go to IDLE immediately, no scan_done.
  - In WAIT_HI/WAIT_LO: the engine cannot be aborted. Finish WAIT_LO, discard the result, go to IDLE.
  - In OUTPUT: complete the pending handshake, then go to IDLE.
- Changes to threshold take effect at the next EVAL. Changes to sv_mask take effect only at the next scan start.
- Synchronous reset mid-search returns to IDLE. The engine must be reset by the same nrst.

Optional Feature:
- ACQ_CONTINUOUS_EN defined: after scan_done, if enable is still 1, go directly to SELECT. This relatches sv_mask and restarts the pass, so scanning continues indefinitely.
- ACQ_CONTINUOUS_EN undefined: after scan_done go to IDLE. A new pass needs enable low for at least one cycle, then high (rising-edge restart).

Test Plan:
- mask=0x0000_0005, threshold=1000, engine model returns acc=5000 for SV1 and 200 for SV3, MAX_RETRY=1 -> search_sv sequence 1,3,3; exactly one detection (sv=1, power=5000); det_count=1; one scan_done pulse.
- mask=0, enable high -> no search_start; scan_done exactly N_SV+1 cycles after leaving IDLE; det_count=0.
- Detection with det_ready held low for 50 cycles -> det_valid and det_* stable for all 50 cycles; next search_start only after the handshake.
- Engine model ignores the first start -> second search_start exactly START_TIMEOUT cycles after the first; pass completes normally.
- enable dropped while search_busy=1 on SV5 with acc above threshold -> no det_valid, no scan_done; busy falls to 0 one cycle after search_busy falls.
- acc == threshold (1000/1000) -> treated as a miss; retry occurs; with ACQ_CONTINUOUS_EN defined and enable held, a second pass starts the cycle after scan_done.
